// File: rtl/cache_pkg.sv
// Shared definitions for the cache and its miss handler: FSM state encoding
// and the default widths both sides are built with.
package cache_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int LINE_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM,
    FILL,
    RESP
  } miss_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a saturated
// statistic stays visibly saturated.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_miss_handler.sv
// Serializes client reads against cache channel 1; on a miss, fetches the line
// from backing memory, writes it into the cache and returns it to the client.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int LINE_WIDTH = LINE_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LINE_WIDTH-1:0] rsp_data,
  output logic                  rsp_was_hit,
  output logic [ADDR_WIDTH-1:0] ch1_in_addr,
  output logic [LINE_WIDTH-1:0] ch1_in_val,
  output logic                  ch1_read,
  output logic                  ch1_write,
  input  logic                  ch1_hit,
  input  logic [LINE_WIDTH-1:0] ch1_out_val,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [LINE_WIDTH-1:0] mem_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  miss_state_t state;
  logic        hit_inc;
  logic        miss_inc;

  assign hit_inc  = (state == CHECK) && ch1_hit;
  assign miss_inc = (state == CHECK) && !ch1_hit;

  // ch1_in_addr doubles as the latched request address and ch1_in_val as the
  // latched fill line, so they stay stable through MEM/FILL without copies.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_was_hit <= 1'b0;
      ch1_in_addr <= '0;
      ch1_in_val  <= '0;
      ch1_read    <= 1'b0;
      ch1_write   <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            ch1_in_addr <= req_addr;
            ch1_read    <= 1'b1;
            req_ready   <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          ch1_read <= 1'b0;
          state    <= CHECK;
        end
        CHECK: begin
          if (ch1_hit) begin
            rsp_data    <= ch1_out_val;
            rsp_was_hit <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= ch1_in_addr;
            state    <= MEM;
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            ch1_in_val <= mem_data;
            ch1_write  <= 1'b1;
            state      <= FILL;
          end
        end
        // The write stays up on the edge where ch1_hit is seen, rewriting the
        // same line once more; that second write carries identical data.
        FILL: begin
          if (ch1_hit) begin
            ch1_write   <= 1'b0;
            rsp_data    <= ch1_in_val;
            rsp_was_hit <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_was_hit <= 1'b0;
            req_ready   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (hit_inc),
    .count   (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (miss_inc),
    .count   (miss_count)
  );

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler with a 4-line direct-mapped cache
// model on channel 1 and backing memory driven from the test tasks.
module tb_cache_miss_handler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_was_hit;
  logic [7:0]  ch1_in_addr;
  logic [31:0] ch1_in_val;
  logic        ch1_read;
  logic        ch1_write;
  logic        ch1_hit;
  logic [31:0] ch1_out_val;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic [1:0]  hit_count;
  logic [1:0]  miss_count;

  int n_cmp = 0;
  int n_fail = 0;

  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] c_data [4];
  logic [5:0]  c_tag [4];
  logic [3:0]  c_val;

  always #5 clock = ~clock;

  cache_miss_handler #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_was_hit (rsp_was_hit),
    .ch1_in_addr (ch1_in_addr),
    .ch1_in_val  (ch1_in_val),
    .ch1_read    (ch1_read),
    .ch1_write   (ch1_write),
    .ch1_hit     (ch1_hit),
    .ch1_out_val (ch1_out_val),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  // Cache model: index = addr[1:0], tag = addr[7:2]; hit is registered and
  // reported for one cycle after a read that matches or after any write.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      c_val       <= '0;
      ch1_hit     <= 1'b0;
      ch1_out_val <= '0;
    end else begin
      ch1_hit <= 1'b0;
      if (pre_we) begin
        c_data[pre_addr[1:0]] <= pre_data;
        c_tag[pre_addr[1:0]]  <= pre_addr[7:2];
        c_val[pre_addr[1:0]]  <= 1'b1;
      end
      if (ch1_read) begin
        ch1_hit     <= c_val[ch1_in_addr[1:0]] && (c_tag[ch1_in_addr[1:0]] == ch1_in_addr[7:2]);
        ch1_out_val <= c_data[ch1_in_addr[1:0]];
      end
      if (ch1_write) begin
        c_data[ch1_in_addr[1:0]] <= ch1_in_val;
        c_tag[ch1_in_addr[1:0]]  <= ch1_in_addr[7:2];
        c_val[ch1_in_addr[1:0]]  <= 1'b1;
        ch1_hit                  <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_was_hit, ch1_read, ch1_write, mem_req} !== 5'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b want 00000", {rsp_valid, rsp_was_hit, ch1_read, ch1_write, mem_req}); end
    n_cmp++; if ({hit_count, miss_count} !== 4'b0) begin n_fail++; $display("FAIL rst_counts: got %h want 0", {hit_count, miss_count}); end
    n_cmp++; if ({rsp_data, ch1_in_addr, ch1_in_val, mem_addr} !== 80'b0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {rsp_data, ch1_in_addr, ch1_in_val, mem_addr}); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_early: got %b want 0", req_ready); end
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_hit();
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h11, 32'hA5A50011);
    preload(8'h12, 32'hA5A50012);
    preload(8'h13, 32'hA5A50013);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'h10;
    tick();
    req_valid = 1'b0;
    n_cmp++; if ({ch1_read, ch1_write, req_ready} !== 3'b100) begin n_fail++; $display("FAIL hit_lookup_ctrl: got %b want 100", {ch1_read, ch1_write, req_ready}); end
    n_cmp++; if (ch1_in_addr !== 8'h10) begin n_fail++; $display("FAIL hit_lookup_addr: got %h want 10", ch1_in_addr); end
    tick();
    n_cmp++; if ({ch1_read, rsp_valid, mem_req} !== 3'b000) begin n_fail++; $display("FAIL hit_check_ctrl: got %b want 000", {ch1_read, rsp_valid, mem_req}); end
    tick();
    n_cmp++; if ({rsp_valid, rsp_was_hit} !== 2'b11) begin n_fail++; $display("FAIL hit_rsp_flags: got %b want 11", {rsp_valid, rsp_was_hit}); end
    n_cmp++; if (rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_rsp_data: got %h want deadbeef", rsp_data); end
    n_cmp++; if ({hit_count, miss_count} !== 4'b0100) begin n_fail++; $display("FAIL hit_counts: got %b want 0100", {hit_count, miss_count}); end
    tick();
    n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL hit_done: got %b want 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_miss_evict();
    int mem_cycles;
    mem_cycles = 0;
    req_valid = 1'b1; req_addr = 8'h20;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (miss_count !== 2'd1) begin n_fail++; $display("FAIL miss_count: got %0d want 1", miss_count); end
    for (int i = 0; i < 3; i++) begin
      if (mem_req === 1'b1 && mem_addr === 8'h20) mem_cycles++;
      tick();
    end
    if (mem_req === 1'b1 && mem_addr === 8'h20) mem_cycles++;
    n_cmp++; if (mem_cycles !== 4) begin n_fail++; $display("FAIL miss_mem_hold: got %0d cycles want 4", mem_cycles); end
    mem_ack = 1'b1; mem_data = 32'h12345678;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    n_cmp++; if ({mem_req, ch1_write, ch1_read} !== 3'b010) begin n_fail++; $display("FAIL miss_fill_ctrl: got %b want 010", {mem_req, ch1_write, ch1_read}); end
    n_cmp++; if ({ch1_in_addr, ch1_in_val} !== {8'h20, 32'h12345678}) begin n_fail++; $display("FAIL miss_fill_line: got %h want 2012345678", {ch1_in_addr, ch1_in_val}); end
    tick();
    n_cmp++; if ({ch1_write, rsp_valid, mem_req} !== 3'b100) begin n_fail++; $display("FAIL miss_fill_wait: got %b want 100", {ch1_write, rsp_valid, mem_req}); end
    tick();
    n_cmp++; if ({rsp_valid, rsp_was_hit, ch1_write} !== 3'b100) begin n_fail++; $display("FAIL miss_rsp_flags: got %b want 100", {rsp_valid, rsp_was_hit, ch1_write}); end
    n_cmp++; if (rsp_data !== 32'h12345678) begin n_fail++; $display("FAIL miss_rsp_data: got %h want 12345678", rsp_data); end
    tick();
    req_valid = 1'b1; req_addr = 8'h20;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if ({rsp_valid, rsp_was_hit, mem_req} !== 3'b110) begin n_fail++; $display("FAIL rehit_flags: got %b want 110", {rsp_valid, rsp_was_hit, mem_req}); end
    n_cmp++; if (rsp_data !== 32'h12345678) begin n_fail++; $display("FAIL rehit_data: got %h want 12345678", rsp_data); end
    n_cmp++; if ({hit_count, miss_count} !== 4'b1001) begin n_fail++; $display("FAIL rehit_counts: got %b want 1001", {hit_count, miss_count}); end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'h11;
    tick();
    req_addr = 8'h12;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({rsp_valid, rsp_was_hit, req_ready, ch1_read} !== 4'b1100) begin n_fail++; $display("FAIL bp_ctrl[%0d]: got %b want 1100", i, {rsp_valid, rsp_was_hit, req_ready, ch1_read}); end
      n_cmp++; if (rsp_data !== 32'hA5A50011) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want a5a50011", i, rsp_data); end
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b want 01", {rsp_valid, req_ready}); end
    n_cmp++; if (hit_count !== 2'd3) begin n_fail++; $display("FAIL bp_hit_count: got %0d want 3", hit_count); end
    tick();
    n_cmp++; if ({req_ready, ch1_read} !== 2'b10) begin n_fail++; $display("FAIL bp_no_stale_req: got %b want 10", {req_ready, ch1_read}); end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_data = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({req_ready, mem_req, rsp_valid, ch1_write, ch1_read} !== 5'b10000) begin n_fail++; $display("FAIL stray_ack[%0d]: got %b want 10000", i, {req_ready, mem_req, rsp_valid, ch1_write, ch1_read}); end
    end
    mem_ack = 1'b0; mem_data = 32'h0;
    n_cmp++; if ({hit_count, miss_count} !== 4'b1101) begin n_fail++; $display("FAIL stray_counts: got %b want 1101", {hit_count, miss_count}); end
  endtask

  task automatic test_reset_mid_mem();
    int rsp_seen;
    rsp_seen = 0;
    req_valid = 1'b1; req_addr = 8'h21;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h21}) begin n_fail++; $display("FAIL rmm_mem_req: got %h want 121", {mem_req, mem_addr}); end
    n_cmp++; if (miss_count !== 2'd2) begin n_fail++; $display("FAIL rmm_miss_count: got %0d want 2", miss_count); end
    tick();
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({mem_req, req_ready, rsp_valid, ch1_write} !== 4'b0000) begin n_fail++; $display("FAIL rmm_async_ctrl: got %b want 0000", {mem_req, req_ready, rsp_valid, ch1_write}); end
    n_cmp++; if ({hit_count, miss_count} !== 4'b0000) begin n_fail++; $display("FAIL rmm_counts: got %b want 0000", {hit_count, miss_count}); end
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rmm_release_early: got %b want 0", req_ready); end
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmm_release_ready: got %b want 1", req_ready); end
    mem_ack = 1'b1; mem_data = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid === 1'b1 || mem_req === 1'b1) rsp_seen++;
      tick();
    end
    mem_ack = 1'b0; mem_data = 32'h0;
    n_cmp++; if (rsp_seen !== 0) begin n_fail++; $display("FAIL rmm_no_response: got %0d active cycles want 0", rsp_seen); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    preload(8'h10, 32'hDEADBEEF);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      req_valid = 1'b1; req_addr = 8'h10;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      n_cmp++; if ({rsp_valid, rsp_was_hit} !== 2'b11) begin n_fail++; $display("FAIL sat_rsp[%0d]: got %b want 11", i, {rsp_valid, rsp_was_hit}); end
      n_cmp++; if (hit_count !== 2'(exp_cnt)) begin n_fail++; $display("FAIL sat_hit_count[%0d]: got %0d want %0d", i, hit_count, exp_cnt); end
      tick();
    end
    n_cmp++; if (miss_count !== 2'd0) begin n_fail++; $display("FAIL sat_miss_count: got %0d want 0", miss_count); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_evict();
    test_backpressure();
    test_stray_ack();
    test_reset_mid_mem();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_handler.md
CACHE_MISS_HANDLER -- requirements
Module: cache_miss_handler

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the address width for the request, cache and memory ports.
REQ-002 Parameter LINE_WIDTH, default 32, SHALL set the data width for the response, cache and memory ports.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the width of each statistics counter.
REQ-004 Port clock, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port reset_n, input, 1, SHALL be an asynchronous, active-low reset.
REQ-006 Ports req_valid (in, 1), req_ready (out, 1) and req_addr (in, ADDR_WIDTH) SHALL form the client read-request channel.
REQ-007 Ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_data (out, LINE_WIDTH) and rsp_was_hit (out, 1) SHALL form the client response channel.
REQ-008 Ports ch1_in_addr (out, ADDR_WIDTH), ch1_in_val (out, LINE_WIDTH), ch1_read (out, 1), ch1_write (out, 1), ch1_hit (in, 1) and ch1_out_val (in, LINE_WIDTH) SHALL connect to the cache's channel 1.
REQ-009 Ports mem_req (out, 1), mem_addr (out, ADDR_WIDTH), mem_ack (in, 1) and mem_data (in, LINE_WIDTH) SHALL form the backing-memory read channel.
REQ-010 Ports hit_count and miss_count (out, CNT_WIDTH each) SHALL report saturating statistics.

Function
REQ-011 States SHALL be IDLE, LOOKUP, CHECK, MEM, FILL and RESP.
REQ-012 IDLE: req_ready=1; on req_valid, latch req_addr and go to LOOKUP.
REQ-013 LOOKUP: ch1_read=1 and ch1_in_addr=latched address for exactly one cycle; next state is CHECK.
REQ-014 CHECK: sample ch1_hit. If 1, latch ch1_out_val, set the hit flag, increment hit_count and go to RESP. If 0, increment miss_count and go to MEM.
REQ-015 MEM: hold mem_req=1 and mem_addr stable until a cycle with mem_ack=1; on that cycle latch mem_data and go to FILL. mem_req SHALL be 0 in the following cycle.
REQ-016 FILL: ch1_write=1 with ch1_in_addr/ch1_in_val held at the latched address/data; on the first cycle ch1_hit=1 is sampled, go to RESP.
REQ-017 The FILL exit edge may perform one redundant rewrite of the same line; this SHALL be harmless.
REQ-018 RESP: rsp_valid=1 with rsp_data and rsp_was_hit stable; on rsp_ready, go to IDLE. A new request is accepted no earlier than the next cycle.
REQ-019 ch1_read and ch1_write SHALL never both be 1; both SHALL be 0 outside LOOKUP and FILL respectively.
REQ-020 Hit latency (accept to rsp_valid) SHALL be 3 cycles. Miss latency SHALL be 3 + memory wait + fill cycles.
REQ-021 Counters SHALL saturate at all-ones and never wrap.
REQ-022 req_ready SHALL be 0 in every state except IDLE; back-to-back requests are serialized.
REQ-023 mem_ack while not in MEM SHALL be ignored.
REQ-024 rsp_ready held high continuously SHALL complete RESP in one cycle.

Reset
REQ-025 While reset_n=0: state=IDLE; req_ready=0; rsp_valid, rsp_was_hit, ch1_read, ch1_write and mem_req=0; all data/address registers=0; counters=0.
REQ-026 Reset mid-operation (MEM or FILL) SHALL abandon the transaction with no response; reset_n SHALL be asserted system-wide so the cache is also reinitialized.
REQ-027 req_ready SHALL rise on the first clock edge after reset_n deasserts.

Structure
REQ-028 Package cache_pkg SHALL hold the state enum (miss_state_t) and default width constants shared with the cache.
REQ-029 A sub-module sat_counter (width parameter, inc input, async active-low reset) SHALL implement each statistics counter.

Verification
REQ-030 Hit: preload addr 0x10 = 0xDEADBEEF; request 0x10 -> rsp_valid 3 cycles after accept, rsp_data=0xDEADBEEF, rsp_was_hit=1, hit_count=1.
REQ-031 Miss with eviction: cache full, request 0x20, mem_ack after 4 cycles with 0x12345678 -> single mem_req pulse train at 0x20, FILL until ch1_hit, rsp_data=0x12345678, rsp_was_hit=0; a re-request of 0x20 then hits.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout.
REQ-033 Reset mid-MEM: reset_n low while mem_req=1 -> mem_req=0 immediately, no response, counters=0, req_ready=1 one edge after release.
REQ-034 Saturation: CNT_WIDTH=2, 5 hits -> hit_count stays 3.
REQ-035 Stray mem_ack in IDLE -> no state change, no response.
